// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared definitions for the MIPS memory stage.
//                Access-size encodings and the byte-lane enable helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Encodings of the mem_size field
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    // Little-endian byte-lane enables for an access of the given size at the
    // given low address bits. The reserved size yields no lanes.
    function automatic logic [3:0] be_from(input logic [1:0] size, input logic [1:0] a);
        logic [3:0] be;
        be = 4'b0000;
        case (size)
            SZ_BYTE: be = 4'b0001 << a;
            SZ_HALF: be = a[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: be = 4'b1111;
            default: be = 4'b0000;
        endcase
        return be;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mem_stage_dmem_array.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_array
//  Description : DEPTH_WORDS x 32 data memory. Asynchronous read, synchronous
//                write with per-byte lane enables. Contents are never reset.
//  Ports       : clk      - clock, rising edge
//                i_we     - write strobe
//                i_be     - byte lane enables (bit n -> data[8n+7:8n])
//                i_addr   - word index (shared by read and write)
//                i_wdata  - lane-steered write data
//                o_rdata  - word at i_addr (combinational)
//  Revision    : 1.0 - initial release
// ============================================================================
module dmem_array #(
    parameter int DEPTH_WORDS = 1024,
    parameter int ADDR_W      = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [3:0]        i_be,
    input  logic [ADDR_W-1:0] i_addr,
    input  logic [31:0]       i_wdata,
    output logic [31:0]       o_rdata
);

    logic [31:0] r_mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int i = 0; i < 4; i++) begin
                if (i_be[i]) begin
                    r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
                end
            end
        end
    end

    assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : MEM stage of the pipelined MIPS core. Byte/half/word loads
//                and stores with alignment checking, load extension and a
//                LATENCY-cycle wait counter that stalls the pipeline.
//  Ports       : clk            - clock, rising edge
//                reset          - synchronous, active-high
//                i_flush        - abort any pending access
//                i_mem_read     - load request
//                i_mem_write    - store request (wins over a read)
//                i_mem_size     - 00 byte, 01 half, 10 word, 11 reserved
//                i_mem_unsigned - zero-extend sub-word loads when set
//                i_addr         - byte address
//                i_write_data   - right-aligned store data
//                o_read_data    - extended load data, valid in completing cycle
//                o_stall        - access in progress, hold upstream
//                o_misalign     - illegal/misaligned access, suppressed
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage
    import mips_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        i_flush,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [1:0]  i_mem_size,
    input  logic        i_mem_unsigned,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_write_data,
    output logic [31:0] o_read_data,
    output logic        o_stall,
    output logic        o_misalign
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);
    // At least one bit so the counter exists even when LATENCY is 0.
    localparam int CNT_W  = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(LATENCY);

    logic [CNT_W-1:0]  r_cnt;
    logic              w_req_raw;
    logic              w_req;
    logic              w_last;
    logic              w_done;
    logic              w_we;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_rword;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [ADDR_W-1:0] w_widx;
    logic              w_unused_addr;

    assign w_req_raw = i_mem_read | i_mem_write;

    always_comb begin
        o_misalign = 1'b0;
        case (i_mem_size)
            SZ_BYTE: o_misalign = 1'b0;
            SZ_HALF: o_misalign = i_addr[0];
            SZ_WORD: o_misalign = |i_addr[1:0];
            default: o_misalign = 1'b1;
        endcase
        o_misalign = o_misalign & w_req_raw;
    end

    // Reset is folded into the request so that stall and the write strobe
    // are quiet in the reset cycle just as they are under flush.
    assign w_req   = w_req_raw & ~o_misalign & ~i_flush & ~reset;
    assign w_last  = (r_cnt == c_CNT_LAST);
    assign o_stall = w_req & ~w_last;
    assign w_done  = w_req & w_last;
    assign w_we    = w_done & i_mem_write;

    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            r_cnt <= '0;
        end else if (o_stall) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end else begin
            r_cnt <= '0;
        end
    end

    // Upper address bits are ignored: addresses wrap modulo the memory size.
    assign w_widx        = i_addr[ADDR_W+1:2];
    assign w_unused_addr = ^{i_addr[31:ADDR_W+2]};

    // Replicate the right-aligned store data across lanes; the byte enables
    // pick which copy lands.
    assign w_be = be_from(i_mem_size, i_addr[1:0]);

    always_comb begin
        w_wdata = i_write_data;
        case (i_mem_size)
            SZ_BYTE: w_wdata = {4{i_write_data[7:0]}};
            SZ_HALF: w_wdata = {2{i_write_data[15:0]}};
            default: w_wdata = i_write_data;
        endcase
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .ADDR_W      (ADDR_W)
    ) u_dmem (
        .clk     (clk),
        .i_we    (w_we),
        .i_be    (w_be),
        .i_addr  (w_widx),
        .i_wdata (w_wdata),
        .o_rdata (w_rword)
    );

    assign w_byte = w_rword[8*i_addr[1:0] +: 8];
    assign w_half = i_addr[1] ? w_rword[31:16] : w_rword[15:0];

    always_comb begin
        o_read_data = '0;
        if (w_done && i_mem_read && !i_mem_write) begin
            case (i_mem_size)
                SZ_BYTE: o_read_data = i_mem_unsigned ? {24'b0, w_byte}
                                                      : {{24{w_byte[7]}}, w_byte};
                SZ_HALF: o_read_data = i_mem_unsigned ? {16'b0, w_half}
                                                      : {{16{w_half[15]}}, w_half};
                default: o_read_data = w_rword;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mem_stage
//  Description : Directed self-checking bench for mem_stage. One instance with
//                LATENCY=2 and one with LATENCY=0 share the same stimulus.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        mem_read;
    logic        mem_write;
    logic [1:0]  mem_size;
    logic        mem_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;

    logic [31:0] rd0, rd2;
    logic        st0, st2;
    logic        mis0, mis2;

    int checks   = 0;
    int failures = 0;
    bit chk_u0   = 1'b1;

    always #5 clk = ~clk;

    mem_stage #(.DEPTH_WORDS(1024), .LATENCY(2)) u_lat2 (
        .clk            (clk),
        .reset          (reset),
        .i_flush        (flush),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_mem_size     (mem_size),
        .i_mem_unsigned (mem_unsigned),
        .i_addr         (addr),
        .i_write_data   (wdata),
        .o_read_data    (rd2),
        .o_stall        (st2),
        .o_misalign     (mis2)
    );

    mem_stage #(.DEPTH_WORDS(1024), .LATENCY(0)) u_lat0 (
        .clk            (clk),
        .reset          (reset),
        .i_flush        (flush),
        .i_mem_read     (mem_read),
        .i_mem_write    (mem_write),
        .i_mem_size     (mem_size),
        .i_mem_unsigned (mem_unsigned),
        .i_addr         (addr),
        .i_write_data   (wdata),
        .o_read_data    (rd0),
        .o_stall        (st0),
        .o_misalign     (mis0)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic rd, input logic wr, input logic [1:0] sz,
                         input logic uns, input logic [31:0] a, input logic [31:0] wd);
        mem_read     = rd;
        mem_write    = wr;
        mem_size     = sz;
        mem_unsigned = uns;
        addr         = a;
        wdata        = wd;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b10, 1'b0, 32'h0, 32'h0);
    endtask

    // Holds a request for three cycles. LATENCY=2 must stall twice then
    // complete; LATENCY=0 must never stall and complete every cycle.
    task automatic access(input string tag, input logic rd, input logic wr,
                          input logic [1:0] sz, input logic uns,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [31:0] exp);
        drive(rd, wr, sz, uns, a, wd);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check({tag, "/stall2"}, 32'(st2), 32'(c < 2));
            check({tag, "/rdata2"}, rd2, (c == 2) ? exp : 32'h0);
            if (chk_u0) begin
                check({tag, "/stall0"}, 32'(st0), 32'h0);
                check({tag, "/rdata0"}, rd0, exp);
            end
            @(posedge clk); #1;
        end
        idle();
    endtask

    task automatic misal(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic [31:0] a);
        drive(rd, wr, sz, 1'b0, a, 32'hFFFF_FFFF);
        @(negedge clk);
        check({tag, "/mis2"},   32'(mis2), 32'h1);
        check({tag, "/stall2"}, 32'(st2),  32'h0);
        check({tag, "/rdata2"}, rd2,       32'h0);
        check({tag, "/mis0"},   32'(mis0), 32'h1);
        check({tag, "/rdata0"}, rd0,       32'h0);
        @(posedge clk); #1;
        idle();
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        // Reset / idle state
        @(negedge clk);
        check("rst/stall2", 32'(st2),  32'h0);
        check("rst/stall0", 32'(st0),  32'h0);
        check("rst/rdata2", rd2,       32'h0);
        check("rst/mis2",   32'(mis2), 32'h0);
        @(posedge clk); #1;

        // Word store then load
        access("sw10", 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEAD_BEEF, 32'h0);
        access("lw10", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_BEEF);
        access("lw10u", 1'b1, 1'b0, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEAD_BEEF);
        // Upper address bits ignored: 0x1010 aliases 0x10
        access("lwwrap", 1'b1, 1'b0, 2'b10, 1'b0, 32'h1010, 32'h0, 32'hDEAD_BEEF);

        // Sub-word loads with extension
        access("lb13",  1'b1, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'hFFFF_FFDE);
        access("lbu13", 1'b1, 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 32'h0000_00DE);
        access("lh10",  1'b1, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'hFFFF_BEEF);
        access("lhu12", 1'b1, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h0000_DEAD);

        // Sub-word stores
        access("sb11",   1'b0, 1'b1, 2'b00, 1'b0, 32'h11, 32'h1234_5677, 32'h0);
        access("lw_sb",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEAD_77EF);
        access("lb11",   1'b1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 32'h0000_0077);
        access("sh12",   1'b0, 1'b1, 2'b01, 1'b0, 32'h12, 32'hAAAA_5555, 32'h0);
        access("lw_sh",  1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5555_77EF);

        // Misaligned / reserved accesses are suppressed
        misal("lw12",   1'b1, 1'b0, 2'b10, 32'h12);
        misal("sh13",   1'b0, 1'b1, 2'b01, 32'h13);
        misal("sz11",   1'b0, 1'b1, 2'b11, 32'h10);
        access("lw_mis", 1'b1, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h5555_77EF);

        // Read and write together act as a write with zero read data
        access("rw14",  1'b1, 1'b1, 2'b10, 1'b0, 32'h14, 32'h0102_0304, 32'h0);
        access("lw14",  1'b1, 1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 32'h0102_0304);

        // Known contents for the abort tests
        access("sw20",  1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h1111_1111, 32'h0);

        // From here the LATENCY=0 instance commits the aborted stores itself,
        // so only the LATENCY=2 instance is checked.
        chk_u0 = 1'b0;

        // Flush in the second wait cycle
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h2222_2222);
        @(negedge clk);
        check("fl/stall_c1", 32'(st2), 32'h1);
        @(posedge clk); #1;
        flush = 1'b1;
        @(negedge clk);
        check("fl/stall_c2", 32'(st2), 32'h0);
        check("fl/rdata_c2", rd2,      32'h0);
        @(posedge clk); #1;
        flush = 1'b0;
        idle();
        access("fl_rb", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1111_1111);

        // Reset in the second wait cycle
        drive(1'b0, 1'b1, 2'b10, 1'b0, 32'h20, 32'h3333_3333);
        @(negedge clk);
        check("rs/stall_c1", 32'(st2), 32'h1);
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rs/stall_c2", 32'(st2), 32'h0);
        @(posedge clk); #1;
        reset = 1'b0;
        idle();
        access("rs_rb", 1'b1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0, 32'h1111_1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
